// File: rtl/absmax_row_quantizer_pkg.sv
// Shared types and constants for the int8 absmax row quantizer.
// Holds the FSM state enum, the QMAX helper and the rounding-mode selection.
package llmint8_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        ROUND_HALF_AWAY = 1'b0,
        ROUND_TRUNCATE  = 1'b1
    } round_mode_e;

    localparam round_mode_e ROUND_MODE = ROUND_HALF_AWAY;

    // Largest magnitude of a symmetric signed integer of the given width.
    function automatic int qmax(input int width);
        return int'((32'd1 << (width - 1)) - 32'd1);
    endfunction

endpackage

// File: rtl/absmax_row_quantizer_if.sv
// Handshake bundle between the quantizer and its upstream/downstream neighbours.
// The slave modport is the quantizer's view; master is the surrounding datapath.
interface absmax_row_quantizer_if #(
    parameter int IN_WIDTH           = 16,
    parameter int ELEMS              = 4,
    parameter int QUANTIZATION_WIDTH = 8,
    parameter int MAX_NUM_WIDTH      = IN_WIDTH
);
    logic [ELEMS-1:0][IN_WIDTH-1:0]           data_in;
    logic                                     data_in_valid;
    logic                                     data_in_ready;
    logic [ELEMS-1:0][QUANTIZATION_WIDTH-1:0] data_out;
    logic                                     data_out_valid;
    logic                                     data_out_ready;
    logic [MAX_NUM_WIDTH-1:0]                 max_num;

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid, max_num
    );

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid, max_num
    );
endinterface

// File: rtl/absmax_row_quantizer_quant_elem.sv
// Per-element quantizer: q = sign(x) * round_half_away(|x| * QMAX / max_num),
// clamped to [-QMAX, QMAX], forced to zero when max_num is zero.
module quant_elem
    import llmint8_pkg::*;
#(
    parameter int IN_WIDTH           = 16,
    parameter int QUANTIZATION_WIDTH = 8,
    parameter int MAX_NUM_WIDTH      = IN_WIDTH
) (
    input  logic [IN_WIDTH-1:0]           x,
    input  logic [MAX_NUM_WIDTH-1:0]      max_num,
    output logic [QUANTIZATION_WIDTH-1:0] q
);
    localparam int QM = qmax(QUANTIZATION_WIDTH);
    // Headroom for 2*|x|*QMAX plus the rounding bias.
    localparam int PW = MAX_NUM_WIDTH + QUANTIZATION_WIDTH + 2;

    logic signed [MAX_NUM_WIDTH-1:0] x_ext_s;
    logic [MAX_NUM_WIDTH-1:0]        abs_s;
    logic [PW-1:0]                   num_s;
    logic [PW-1:0]                   den_s;
    logic [PW-1:0]                   quot_s;
    logic [QUANTIZATION_WIDTH-1:0]   mag_s;

    // Magnitude, scaled rounding divide, clamp and re-sign.
    always_comb begin
        x_ext_s = MAX_NUM_WIDTH'($signed(x));
        if (x[IN_WIDTH-1]) begin
            abs_s = MAX_NUM_WIDTH'(-x_ext_s);
        end else begin
            abs_s = MAX_NUM_WIDTH'(x_ext_s);
        end

        num_s = PW'(abs_s) * PW'(2 * QM);
        if (ROUND_MODE == ROUND_HALF_AWAY) begin
            num_s = num_s + PW'(max_num);
        end else begin
            num_s = num_s;
        end
        den_s = PW'(max_num) << 1;

        if (max_num == {MAX_NUM_WIDTH{1'b0}}) begin
            quot_s = {PW{1'b0}};
        end else begin
            quot_s = num_s / den_s;
        end

        if (quot_s > PW'(QM)) begin
            mag_s = QUANTIZATION_WIDTH'(QM);
        end else begin
            mag_s = QUANTIZATION_WIDTH'(quot_s);
        end

        if (x[IN_WIDTH-1]) begin
            q = -mag_s;
        end else begin
            q = mag_s;
        end
    end
endmodule

// File: rtl/absmax_row_quantizer.sv
// Row-block int8 quantizer: buffers NUM_BEATS beats while tracking absmax,
// then replays them quantized against that absmax, which is presented as max_num.
module absmax_row_quantizer
    import llmint8_pkg::*;
#(
    parameter int IN_WIDTH           = 16,
    parameter int IN_SIZE            = 4,
    parameter int IN_PARALLELISM     = 1,
    parameter int NUM_BEATS          = 4,
    parameter int QUANTIZATION_WIDTH = 8,
    parameter int MAX_NUM_WIDTH      = IN_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    absmax_row_quantizer_if.slave  io
);
    localparam int ELEMS = IN_PARALLELISM * IN_SIZE;
    localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    typedef logic [ELEMS-1:0][IN_WIDTH-1:0] beat_t;

    state_e                                   state_r;
    state_e                                   next_state_s;
    logic [CNT_W-1:0]                         cnt_r;
    logic [MAX_NUM_WIDTH-1:0]                 absmax_r;
    logic [MAX_NUM_WIDTH-1:0]                 max_num_r;
    logic [MAX_NUM_WIDTH-1:0]                 beat_max_s;
    beat_t                                    buf_r [NUM_BEATS];
    beat_t                                    cur_beat_s;
    logic                                     in_ready_s;
    logic                                     out_valid_s;
    logic                                     in_hs_s;
    logic                                     out_hs_s;
    logic                                     last_s;
    logic [ELEMS-1:0][QUANTIZATION_WIDTH-1:0] q_s;

    function automatic logic [MAX_NUM_WIDTH-1:0] abs_of(input logic [IN_WIDTH-1:0] x);
        logic signed [MAX_NUM_WIDTH-1:0] ext;
        ext = MAX_NUM_WIDTH'($signed(x));
        return x[IN_WIDTH-1] ? MAX_NUM_WIDTH'(-ext) : MAX_NUM_WIDTH'(ext);
    endfunction

    assign last_s     = (cnt_r == CNT_W'(NUM_BEATS - 1));
    assign in_hs_s    = in_ready_s & io.data_in_valid;
    assign out_hs_s   = out_valid_s & io.data_out_ready;
    assign cur_beat_s = buf_r[cnt_r];

    // Running absmax folded with every element of the beat being presented.
    always_comb begin
        beat_max_s = absmax_r;
        for (int i = 0; i < ELEMS; i++) begin
            if (abs_of(io.data_in[i]) > beat_max_s) begin
                beat_max_s = abs_of(io.data_in[i]);
            end else begin
                beat_max_s = beat_max_s;
            end
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        next_state_s = state_r;
        in_ready_s   = 1'b0;
        out_valid_s  = 1'b0;
        case (state_r)
            COLLECT: begin
                in_ready_s = 1'b1;
                if (io.data_in_valid && last_s) begin
                    next_state_s = EMIT;
                end else begin
                    next_state_s = COLLECT;
                end
            end
            EMIT: begin
                out_valid_s = 1'b1;
                if (io.data_out_ready && last_s) begin
                    next_state_s = COLLECT;
                end else begin
                    next_state_s = EMIT;
                end
            end
            default: begin
                next_state_s = COLLECT;
            end
        endcase
    end

    // State, beat counter, running absmax and the latched block maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= COLLECT;
            cnt_r     <= {CNT_W{1'b0}};
            absmax_r  <= {MAX_NUM_WIDTH{1'b0}};
            max_num_r <= {MAX_NUM_WIDTH{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (in_hs_s) begin
                if (last_s) begin
                    cnt_r     <= {CNT_W{1'b0}};
                    absmax_r  <= {MAX_NUM_WIDTH{1'b0}};
                    max_num_r <= beat_max_s;
                end else begin
                    cnt_r    <= cnt_r + CNT_W'(1);
                    absmax_r <= beat_max_s;
                end
            end else if (out_hs_s) begin
                if (last_s) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
        end
    end

    // Beat buffer; contents are irrelevant until written, so no reset.
    always_ff @(posedge clk) begin
        if (in_hs_s) begin
            buf_r[cnt_r] <= io.data_in;
        end
    end

    for (genvar g = 0; g < ELEMS; g++) begin : g_quant
        quant_elem #(
            .IN_WIDTH           (IN_WIDTH),
            .QUANTIZATION_WIDTH (QUANTIZATION_WIDTH),
            .MAX_NUM_WIDTH      (MAX_NUM_WIDTH)
        ) u_quant_elem (
            .x       (cur_beat_s[g]),
            .max_num (max_num_r),
            .q       (q_s[g])
        );
    end

    assign io.data_in_ready  = in_ready_s;
    assign io.data_out_valid = out_valid_s;
    assign io.max_num        = max_num_r;
    assign io.data_out       = out_valid_s ? q_s : {ELEMS*QUANTIZATION_WIDTH{1'b0}};
endmodule

// File: tb/tb_absmax_row_quantizer.sv
// Directed scoreboard bench for absmax_row_quantizer with NUM_BEATS=2, IN_SIZE=4.
module tb_absmax_row_quantizer;
    localparam int IW = 16;
    localparam int N  = 4;
    localparam int NB = 2;
    localparam int QW = 8;
    localparam int MW = 16;

    typedef struct {
        logic [N-1:0][QW-1:0] q;
        logic [MW-1:0]        m;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   blk[NB][N];
    int   first_wait;
    logic [N-1:0][QW-1:0] hold_q;
    logic [MW-1:0]        hold_m;

    always #5 clk = ~clk;

    absmax_row_quantizer_if #(
        .IN_WIDTH(IW), .ELEMS(N), .QUANTIZATION_WIDTH(QW), .MAX_NUM_WIDTH(MW)
    ) bus ();

    absmax_row_quantizer #(
        .IN_WIDTH(IW), .IN_SIZE(N), .IN_PARALLELISM(1), .NUM_BEATS(NB),
        .QUANTIZATION_WIDTH(QW), .MAX_NUM_WIDTH(MW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_q(input int x, input int m);
        real r;
        int  mag;
        if (m == 0) return 0;
        r   = ((x < 0) ? -x : x) * 127.0 / m;
        mag = $rtoi(r + 0.5);
        if (mag > 127) mag = 127;
        return (x < 0) ? -mag : mag;
    endfunction

    task automatic push_block();
        int   m;
        exp_t e;
        m = 0;
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < N; i++)
                if (((blk[b][i] < 0) ? -blk[b][i] : blk[b][i]) > m)
                    m = (blk[b][i] < 0) ? -blk[b][i] : blk[b][i];
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < N; i++) e.q[i] = QW'(model_q(blk[b][i], m));
            e.m = MW'(m);
            sb.push_back(e);
        end
    endtask

    task automatic drive_block(input int gap);
        int w;
        for (int b = 0; b < NB; b++) begin
            for (int g = 0; g < gap; g++) begin
                bus.data_in_valid = 1'b0;
                for (int i = 0; i < N; i++) bus.data_in[i] = IW'($urandom);
                @(posedge clk); #1;
            end
            for (int i = 0; i < N; i++) bus.data_in[i] = IW'(blk[b][i]);
            bus.data_in_valid = 1'b1;
            w = 0;
            @(negedge clk);
            while (bus.data_in_ready !== 1'b1 && w < 50) begin
                w++;
                @(negedge clk);
            end
            if (b == 0) first_wait = w;
            if (w >= 50) begin
                checks++;
                errors++;
                $error("FAIL in_ready_timeout observed=0 expected=1");
            end
            @(posedge clk); #1;
            bus.data_in_valid = 1'b0;
            for (int i = 0; i < N; i++) bus.data_in[i] = IW'($urandom);
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout observed=%0d expected=0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    // Scoreboard: every output handshake pops and compares one expected beat.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.data_out_valid === 1'b1 && bus.data_out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_beat observed=%0h expected=none", bus.data_out);
            end else begin
                e = sb.pop_front();
                chk("data_out", 64'(bus.data_out), 64'(e.q));
                chk("max_num", 64'(bus.max_num), 64'(e.m));
                chk("in_ready_in_emit", 64'(bus.data_in_ready), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.data_in = '0;
        bus.data_in_valid = 1'b0;
        bus.data_out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(bus.data_out_valid), 64'd0);
        chk("rst_max_num", 64'(bus.max_num), 64'd0);
        chk("rst_data_out", 64'(bus.data_out), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.data_in_ready), 64'd1);
        @(posedge clk); #1;

        // 1: basic block, latency and explicit reference values
        blk = '{'{10, -20, 30, -40}, '{50, -100, 0, 5}};
        push_block();
        drive_block(0);
        @(negedge clk);
        chk("latency_valid", 64'(bus.data_out_valid), 64'd1);
        chk("t1_max", 64'(bus.max_num), 64'd100);
        chk("t1_beat0", 64'(bus.data_out), 64'hCD_26_E7_0D);
        wait_drain();

        // 2: all-zero block
        blk = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
        push_block();
        drive_block(0);
        wait_drain();

        // 3: most-negative element and half-way rounding
        blk = '{'{-32768, 16384, 16384, 16384}, '{16384, 16384, 16384, 16384}};
        push_block();
        drive_block(0);
        wait_drain();

        // 4: toggling input valid, then output backpressure on the second beat
        blk = '{'{1000, -2000, 3, 4}, '{-5, 600, -700, 8}};
        push_block();
        drive_block(2);
        @(negedge clk);
        @(posedge clk); #1;
        bus.data_out_ready = 1'b0;
        hold_q = sb[0].q;
        hold_m = sb[0].m;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_valid", 64'(bus.data_out_valid), 64'd1);
            chk("bp_data_out", 64'(bus.data_out), 64'(hold_q));
            chk("bp_max_num", 64'(bus.max_num), 64'(hold_m));
        end
        @(posedge clk); #1;
        bus.data_out_ready = 1'b1;
        wait_drain();

        // 5: asynchronous reset after one of two output beats
        blk = '{'{300, -50, 20, 1}, '{2, 3, -600, 9}};
        push_block();
        drive_block(0);
        @(negedge clk);
        @(posedge clk); #1;
        bus.data_out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(bus.data_out_valid), 64'd0);
        chk("arst_max_num", 64'(bus.max_num), 64'd0);
        chk("arst_data_out", 64'(bus.data_out), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.data_out_ready = 1'b1;
        blk = '{'{40, -10, 0, 1}, '{2, -3, 20, 5}};
        push_block();
        drive_block(0);
        wait_drain();

        // 6: back-to-back blocks, absmax 100 then 7
        blk = '{'{100, -1, 2, 3}, '{-4, 50, 6, 7}};
        push_block();
        drive_block(0);
        blk = '{'{7, -3, 1, 0}, '{-2, 5, 6, -7}};
        push_block();
        drive_block(0);
        chk("in_ready_low_cycles", 64'(first_wait), 64'(NB));
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
